// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants, index types and sequencer states for the 1024-point FFT
package fft_pkg;
  localparam int N_LOG2  = 10;
  localparam int N_PAIRS = 1 << (N_LOG2 - 1);
  localparam int STAGE_W = 4;
  localparam int PAIR_W  = 9;

  typedef logic [STAGE_W-1:0] stage_t;
  typedef logic [PAIR_W-1:0]  pair_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} seq_state_t;
endpackage

// File: rtl/fft_delay_line.sv
// rtl/fft_delay_line.sv - fixed-depth shift register aligning read indices with butterfly write-back
module fft_delay_line #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] taps_q [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) taps_q[i] <= '0;
    end else begin
      taps_q[0] <= data_i;
      for (int i = 1; i < DEPTH; i++) taps_q[i] <= taps_q[i-1];
    end
  end

  assign data_o = taps_q[DEPTH-1];

endmodule

// File: rtl/fft_sequencer.sv
// rtl/fft_sequencer.sv - issues every (stage, pair) of a radix-2 FFT, one per clock, with
// a drain gap per stage so stage s+1 never reads before stage s has finished writing.
module fft_sequencer #(
  parameter int N_LOG2   = fft_pkg::N_LOG2,
  parameter int PAIR_W   = fft_pkg::PAIR_W,
  parameter int STAGE_W  = fft_pkg::STAGE_W,
  parameter int PIPE_LAT = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_rd_valid,
  output logic [STAGE_W-1:0] o_rd_stage,
  output logic [PAIR_W-1:0]  o_rd_pair,
  output logic               o_wr_valid,
  output logic [STAGE_W-1:0] o_wr_stage,
  output logic [PAIR_W-1:0]  o_wr_pair,
  output logic               o_bank
);
  import fft_pkg::*;

  localparam int                 WR_W       = 1 + STAGE_W + PAIR_W;
  localparam logic [PAIR_W-1:0]  PAIR_LAST  = PAIR_W'((1 << (N_LOG2 - 1)) - 1);
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(N_LOG2 - 1);
  localparam logic [3:0]         DRAIN_INIT = 4'(PIPE_LAT - 1);

  seq_state_t         state_q;
  logic               busy_q;
  logic               done_q;
  logic               rd_valid_q;
  logic [STAGE_W-1:0] stage_q;
  logic [PAIR_W-1:0]  pair_q;
  logic [3:0]         drain_q;

  logic [PAIR_W-1:0]  pair_d;
  logic [STAGE_W-1:0] stage_d;
  logic [3:0]         drain_d;
  logic [WR_W-1:0]    wr_d;
  logic [WR_W-1:0]    wr_q;

  assign pair_d  = pair_q + 1'b1;
  assign stage_d = stage_q + 1'b1;
  assign drain_d = drain_q - 1'b1;

  // Outputs are set on the edge that enters a state, so they describe the current cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      stage_q    <= '0;
      pair_q     <= '0;
      drain_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start) begin
            state_q    <= RUN;
            busy_q     <= 1'b1;
            rd_valid_q <= 1'b1;
            stage_q    <= '0;
            pair_q     <= '0;
          end
        end
        RUN: begin
          if (pair_q == PAIR_LAST) begin
            state_q    <= DRAIN;
            rd_valid_q <= 1'b0;
            drain_q    <= DRAIN_INIT;
          end else begin
            pair_q <= pair_d;
          end
        end
        DRAIN: begin
          if (drain_q != '0) begin
            drain_q <= drain_d;
          end else if (stage_q == STAGE_LAST) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q    <= RUN;
            rd_valid_q <= 1'b1;
            stage_q    <= stage_d;
            pair_q     <= '0;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  fft_delay_line #(
    .WIDTH(WR_W),
    .DEPTH(PIPE_LAT)
  ) u_wr_delay (
    .clk_i (i_clk),
    .rst_i (i_rst),
    .data_i({rd_valid_q, stage_q, pair_q}),
    .data_o(wr_q)
  );

  assign {o_wr_valid, o_wr_stage, o_wr_pair} = wr_q;

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_rd_valid = rd_valid_q;
  assign o_rd_stage = stage_q;
  assign o_rd_pair  = pair_q;
  assign o_bank     = stage_q[0];

endmodule
